// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
//
// Elastic pipeline register between core pipeline stages. It holds up to
// DEPTH entries in a valid/ready buffer, absorbs back-pressure from a stalled
// downstream stage, preserves order, and moves at most one item in and one
// item out per cycle. flush discards all contents on a branch redirect or an
// exception.
//
// Parameters
//   WIDTH      payload width in bits (>= 1)
//   DEPTH      number of storage entries (>= 1, any value)
//   RESET_VAL  value driven on out_data while the buffer is empty
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rstn       synchronous active-low reset; takes priority over flush
//   in_valid   upstream offers in_data
//   in_ready   buffer accepts in_data this cycle (state and flush only)
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts out_data this cycle
//   out_data   head-of-buffer payload, or RESET_VAL when empty
//   flush      discard all contents; the buffer is empty from the next cycle
//   count      current occupancy, 0..DEPTH
//
// Build option
//   PIPE_STAGE_BYPASS_EN  When defined, an empty buffer forwards in_data to
//                         out_data in the same cycle (latency 0). If the
//                         downstream takes it, the item is never stored.
//                         When not defined, no combinational in->out path
//                         exists and the latency is always one cycle.
// -----------------------------------------------------------------------------
module pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  // A single-entry buffer still needs a one-bit pointer to declare.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic stored_valid;
  logic bypass;
  logic push;
  logic pop;

  // Pointers wrap DEPTH-1 -> 0 so that non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake and output mux. in_ready looks only at occupancy and flush so
  // that no ready path chains combinationally through this stage.
  always_comb begin
    in_ready     = (count_q < CNT_W'(DEPTH)) && !flush;
    stored_valid = (count_q != '0) && !flush;
`ifdef PIPE_STAGE_BYPASS_EN
    bypass       = (count_q == '0) && in_valid && !flush;
`else
    bypass       = 1'b0;
`endif
    out_valid    = stored_valid || bypass;

    if (count_q != '0) begin
      out_data = mem_q[rd_ptr_q];
`ifdef PIPE_STAGE_BYPASS_EN
    end else if (bypass) begin
      out_data = in_data;
`endif
    end else begin
      out_data = RESET_VAL;
    end

    // A bypassed item that the downstream takes in the same cycle is never
    // written; otherwise an accepted item is stored as a normal push.
    push  = in_valid && in_ready && !(bypass && out_ready);
    pop   = stored_valid && out_ready;
    count = count_q;
  end

  // Next-state logic for pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the payload array has no reset. An entry is only read after it has
  // been written, and an empty buffer shows RESET_VAL through the output mux.
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage
//
// Self-checking bench for pipe_stage in the default build (no bypass).
//   u_d2 : WIDTH=8, DEPTH=2, RESET_VAL=8'h5A. Driven from a vector table
//          covering reset, fill/drain, flush and flush-during-reset, plus a
//          hand-written back-to-back streaming sequence.
//   u_d1 : WIDTH=8, DEPTH=1. Driven with random traffic.
//   u_d3 : WIDTH=8, DEPTH=3. Directed pointer-wrap sequence, then random
//          traffic.
// The random phase compares each cycle against a ring-buffer scoreboard.
// Inputs change on the falling edge and outputs are sampled 1 ns later,
// which is well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- DEPTH=2
  logic       d2_iv, d2_ir, d2_ov, d2_or, d2_fl;
  logic [7:0] d2_id, d2_od;
  logic [1:0] d2_cnt;

  pipe_stage #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'h5A)) u_d2 (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (d2_iv),
    .in_ready (d2_ir),
    .in_data  (d2_id),
    .out_valid(d2_ov),
    .out_ready(d2_or),
    .out_data (d2_od),
    .flush    (d2_fl),
    .count    (d2_cnt)
  );

  // ------------------------------------------ DEPTH=1 (idx 0), DEPTH=3 (idx 1)
  logic       r_iv [2];
  logic       r_or [2];
  logic       r_fl [2];
  logic [7:0] r_id [2];
  logic       r_ir [2];
  logic       r_ov [2];
  logic [7:0] r_od [2];
  logic [1:0] r_cnt [2];
  logic [0:0] cnt_d1;
  logic [1:0] cnt_d3;

  assign r_cnt[0] = {1'b0, cnt_d1};
  assign r_cnt[1] = cnt_d3;

  pipe_stage #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (r_iv[0]),
    .in_ready (r_ir[0]),
    .in_data  (r_id[0]),
    .out_valid(r_ov[0]),
    .out_ready(r_or[0]),
    .out_data (r_od[0]),
    .flush    (r_fl[0]),
    .count    (cnt_d1)
  );

  pipe_stage #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (r_iv[1]),
    .in_ready (r_ir[1]),
    .in_data  (r_id[1]),
    .out_valid(r_ov[1]),
    .out_ready(r_or[1]),
    .out_data (r_od[1]),
    .flush    (r_fl[1]),
    .count    (cnt_d3)
  );

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic       rstn;
    logic       iv;
    logic [7:0] id;
    logic       orr;
    logic       fl;
    logic       chk;   // 0 while DUT state is still undefined
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rs, input logic iv, input logic [7:0] id,
                     input logic orr, input logic fl, input logic chk,
                     input logic e_ir, input logic e_ov,
                     input logic [7:0] e_od, input logic [1:0] e_cnt);
    vec_t v;
    v.rstn = rs;   v.iv = iv;     v.id = id;     v.orr = orr;    v.fl = fl;
    v.chk  = chk;  v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;  v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // ------------------------------------------------------------ scoreboard
  int         dep [2];
  logic [7:0] sb_mem [2][4];
  int         sb_head [2];
  int         sb_cnt [2];
  logic       hold [2];

  task automatic model_step(input int i, input string tag);
    logic       e_ir, e_ov, pushm, popm;
    logic [7:0] e_od;
    e_ir = (sb_cnt[i] < dep[i]) && !r_fl[i];
    e_ov = (sb_cnt[i] != 0) && !r_fl[i];
    e_od = (sb_cnt[i] != 0) ? sb_mem[i][sb_head[i]] : 8'h00;
    check({tag, " in_ready"},  32'(r_ir[i]),  32'(e_ir));
    check({tag, " out_valid"}, 32'(r_ov[i]),  32'(e_ov));
    check({tag, " out_data"},  32'(r_od[i]),  32'(e_od));
    check({tag, " count"},     32'(r_cnt[i]), 32'(sb_cnt[i]));
    pushm = r_iv[i] && e_ir;
    popm  = e_ov && r_or[i];
    if (r_fl[i]) begin
      sb_cnt[i]  = 0;
      sb_head[i] = 0;
    end else begin
      if (popm) begin
        sb_head[i] = (sb_head[i] + 1) % 4;
        sb_cnt[i]--;
      end
      if (pushm) begin
        sb_mem[i][(sb_head[i] + sb_cnt[i]) % 4] = r_id[i];
        sb_cnt[i]++;
      end
    end
    // Upstream keeps offering a refused item unless a flush redirects it.
    hold[i] = r_iv[i] && !pushm && !r_fl[i];
  endtask

  // ----------------------------------------------------------------- test
  initial begin
    rstn  = 1'b0;
    d2_iv = 1'b0; d2_id = '0; d2_or = 1'b0; d2_fl = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_iv[i] = 1'b0; r_id[i] = '0; r_or[i] = 1'b0; r_fl[i] = 1'b0;
    end

    //   rstn iv  id    or  fl  chk  ir  ov  od     cnt
    // reset held for two cycles with a valid offer: nothing captured
    add(0, 1, 8'hAA, 0, 0, 0,   0,  0,  8'h00, 0);
    add(0, 1, 8'hAA, 0, 0, 1,   1,  0,  8'h5A, 0);
    add(1, 0, 8'h00, 0, 0, 1,   1,  0,  8'h5A, 0);
    // fill to full, hold 33 while full, then drain in order
    add(1, 1, 8'h11, 0, 0, 1,   1,  0,  8'h5A, 0);
    add(1, 1, 8'h22, 0, 0, 1,   1,  1,  8'h11, 1);
    add(1, 1, 8'h33, 0, 0, 1,   0,  1,  8'h11, 2);
    add(1, 1, 8'h33, 1, 0, 1,   0,  1,  8'h11, 2);
    add(1, 1, 8'h33, 1, 0, 1,   1,  1,  8'h22, 1);
    add(1, 0, 8'h00, 1, 0, 1,   1,  1,  8'h33, 1);
    add(1, 0, 8'h00, 1, 0, 1,   1,  0,  8'h5A, 0);
    // fill to two, flush with a valid offer: 44/55/66 never appear
    add(1, 1, 8'h44, 0, 0, 1,   1,  0,  8'h5A, 0);
    add(1, 1, 8'h55, 0, 0, 1,   1,  1,  8'h44, 1);
    add(1, 1, 8'h66, 0, 1, 1,   0,  0,  8'h44, 2);
    add(1, 0, 8'h00, 1, 0, 1,   1,  0,  8'h5A, 0);
    add(1, 1, 8'h77, 1, 0, 1,   1,  0,  8'h5A, 0);
    add(1, 0, 8'h00, 1, 0, 1,   1,  1,  8'h77, 1);
    add(1, 0, 8'h00, 1, 0, 1,   1,  0,  8'h5A, 0);
    // reset together with flush in mid-traffic drops the stored entry
    add(1, 1, 8'h88, 0, 0, 1,   1,  0,  8'h5A, 0);
    add(0, 1, 8'h99, 0, 1, 1,   0,  0,  8'h88, 1);
    add(1, 0, 8'h00, 0, 0, 1,   1,  0,  8'h5A, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rstn  = vecs[i].rstn;
      d2_iv = vecs[i].iv;
      d2_id = vecs[i].id;
      d2_or = vecs[i].orr;
      d2_fl = vecs[i].fl;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d in_ready", i),  32'(d2_ir),  32'(vecs[i].e_ir));
        check($sformatf("vec%0d out_valid", i), 32'(d2_ov),  32'(vecs[i].e_ov));
        check($sformatf("vec%0d out_data", i),  32'(d2_od),  32'(vecs[i].e_od));
        check($sformatf("vec%0d count", i),     32'(d2_cnt), 32'(vecs[i].e_cnt));
      end
    end

    // Streaming: 0x01..0x10 back-to-back with out_ready high. Each item
    // appears one cycle after its push and occupancy never exceeds 1.
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      d2_iv = (k < 16);
      d2_id = 8'(k + 1);
      d2_or = 1'b1;
      d2_fl = 1'b0;
      #1;
      check($sformatf("stream%0d out_valid", k), 32'(d2_ov), 32'(k >= 1));
      check($sformatf("stream%0d count", k), 32'(d2_cnt), (k >= 1) ? 32'd1 : 32'd0);
      if (k >= 1) check($sformatf("stream%0d out_data", k), 32'(d2_od), 32'(k));
    end
    @(negedge clk);
    d2_iv = 1'b0;
    #1;
    check("stream drained count", 32'(d2_cnt), 32'd0);
    check("stream drained out_valid", 32'(d2_ov), 32'd0);
    d2_or = 1'b0;

    // DEPTH=3: simultaneous push/pop at count=1 across the pointer wrap.
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn    = 1'b1;
    r_iv[1] = 1'b1;
    r_id[1] = 8'hA1;
    r_or[1] = 1'b0;
    #1;
    check("wrap start count", 32'(r_cnt[1]), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      r_iv[1] = 1'b1;
      r_id[1] = 8'(8'hA1 + k);
      r_or[1] = 1'b1;
      #1;
      check($sformatf("wrap%0d out_data", k), 32'(r_od[1]), 32'(8'hA0 + k));
      check($sformatf("wrap%0d count", k), 32'(r_cnt[1]), 32'd1);
      check($sformatf("wrap%0d out_valid", k), 32'(r_ov[1]), 32'd1);
    end
    @(negedge clk);
    r_iv[1] = 1'b0;
    #1;
    check("wrap last out_data", 32'(r_od[1]), 32'hA6);
    @(negedge clk);
    #1;
    check("wrap drained count", 32'(r_cnt[1]), 32'd0);

    // Random traffic on DEPTH=1 and DEPTH=3 against the scoreboard.
    @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_iv[i] = 1'b0; r_or[i] = 1'b0; r_fl[i] = 1'b0;
      sb_head[i] = 0; sb_cnt[i] = 0; hold[i] = 1'b0;
    end
    dep[0] = 1;
    dep[1] = 3;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      if (c != 0) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          r_iv[i] = 1'($urandom_range(0, 1));
          r_id[i] = 8'($urandom_range(0, 255));
        end
        r_or[i] = 1'($urandom_range(0, 1));
        r_fl[i] = ($urandom_range(0, 63) == 0);
      end
      #1;
      model_step(0, "rand d1");
      model_step(1, "rand d3");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised elastic pipeline register: the next generation of the plain write-enabled register used for IR/PC, generalised to a DEPTH-entry valid/ready buffer with flush and occupancy reporting. Sits between core pipeline stages (fetch→decode, decode→execute) so that back-pressure from a stalled stage is absorbed without losing or duplicating instructions. Order-preserving; one transfer in and one out per cycle maximum.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 2, number of storage entries (≥1; need not be a power of two)
- RESET_VAL, 0, value driven on out_data whenever the buffer is empty
- clk  input  1  clock, all state updates on rising edge
- rstn  input  1  reset, synchronous, active-low
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  buffer will accept in_data this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  head-of-buffer payload
- flush  input  1  discard all contents (branch redirect / exception)
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH×WIDTH array, write pointer, read pointer, occupancy counter; pointers wrap DEPTH-1→0.
- Push = in_valid && in_ready; writes in_data at write pointer, pointer advances.
- Pop = out_valid && out_ready; read pointer advances.
- in_ready = (count < DEPTH) && !flush; depends only on state and flush, never on out_ready (no combinational ready chain).
- out_valid = (count != 0) && !flush.
- out_data = entry at read pointer when count != 0, else RESET_VAL.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full (count==DEPTH): in_ready=0; a pop the same cycle frees an entry for the next cycle only.
- Empty (count==0): out_valid=0; a push the same cycle becomes visible next cycle (see Configuration).
- flush=1: no push, no pop; next edge sets count=0, both pointers=0. Array contents need not be cleared.
- flush and rstn both asserted: reset wins (identical result).
- in_valid while in_ready=0: no state change; upstream must hold in_data/in_valid.

## Timing
- Reset (rstn=0 at edge): count=0, pointers=0; following cycle in_ready=1, out_valid=0, out_data=RESET_VAL, count=0. Reset mid-traffic drops all entries.
- Latency in→out: 1 cycle (push at edge N, out_valid at N+1).
- Throughput: 1 item/cycle sustained for DEPTH≥2 with out_ready held high; DEPTH=1 gives 1 item per 2 cycles.
- Flush effect: combinational on in_ready/out_valid in the asserted cycle; buffer empty from the next cycle.
- All outputs except the flush gating and out_data mux are register-driven.

## Configuration
- PIPE_STAGE_BYPASS_EN defined: when count==0 and in_valid=1 and flush=0, out_valid=1 and out_data=in_data in the same cycle; if out_ready=1 the item passes through without being stored (count stays 0), otherwise it is stored as a normal push. Latency 0 when empty.
- Not defined: no in→out combinational path; latency always 1 cycle as above.

## Test plan
- Reset: drive rstn=0 for 2 cycles with in_valid=1, in_data=8'hAA → in_ready=1, out_valid=0, out_data=RESET_VAL, count=0 after release; no entry captured.
- Fill/drain (WIDTH=8, DEPTH=2, out_ready=0): push 8'h11, 8'h22 → count=2, in_ready=0; 8'h33 held; set out_ready=1 → outputs 11, 22, 33 in order, count returns to 0.
- Streaming: out_ready=1, push 0x01..0x10 back-to-back → 16 outputs in order, one per cycle, count ≤1, latency 1 (0 with PIPE_STAGE_BYPASS_EN).
- Simultaneous push/pop at count=1 → count stays 1, data order preserved across pointer wrap for DEPTH=3.
- Flush with count=2 and in_valid=1 → in_ready=0, out_valid=0 that cycle; next cycle count=0, out_data=RESET_VAL, flushed items never appear.
- Random valid/ready (10k cycles, DEPTH=1 and 3) vs scoreboard → no loss, duplication or reordering; count always equals pushes − pops.
